// File: rtl/vga_pkg.sv
// Shared constants for the VGA pixel path: visible-area size, coordinate width
// and the one-bit direction encoding used by the bouncing-box axes.
package vga_pkg;

    localparam int H_VISIBLE = 640;
    localparam int V_VISIBLE = 480;
    localparam int COORD_W   = 10;

    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_t;

endpackage

// File: rtl/vga_bouncing_box_if.sv
// Pixel-stage bundle: sync-generator coordinates, board controls and the registered colour.
interface vga_bouncing_box_if #(
    parameter int COLOR_W = 3
);
    import vga_pkg::*;

    logic [COLOR_W-1:0] switch;
    logic               pause;
    logic [COORD_W-1:0] pixel_x;
    logic [COORD_W-1:0] pixel_y;
    logic               video_on;
    logic [COLOR_W-1:0] rgb;

    modport master (output switch, pause, pixel_x, pixel_y, video_on, input rgb);
    modport slave  (input switch, pause, pixel_x, pixel_y, video_on, output rgb);

endinterface

// File: rtl/box_axis.sv
// One axis of the bouncing box: position/direction register pair that steps by STEP
// on step_en and reflects off 0 and LIMIT; flip pulses combinationally on a reflection.
module box_axis
    import vga_pkg::*;
#(
    parameter int LIMIT = 600,
    parameter int STEP  = 1,
    parameter int INIT  = 320
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               step_en,
    output logic [COORD_W-1:0] pos,
    output logic               flip
);

    logic [COORD_W-1:0] r_pos;
    dir_t               r_dir;
    logic [COORD_W-1:0] w_posNext;
    dir_t               w_dirNext;
    logic [COORD_W:0]   w_posUp;
    logic [COORD_W:0]   w_posWide;

    // One spare bit so pos+STEP cannot wrap before the limit compare.
    assign w_posWide = {1'b0, r_pos};
    assign w_posUp   = w_posWide + (COORD_W+1)'(STEP);

    always_comb begin
        w_posNext = r_pos;
        w_dirNext = r_dir;
        flip      = 1'b0;
        if (step_en) begin
            if (r_dir == DIR_POS) begin
                if (w_posUp >= (COORD_W+1)'(LIMIT)) begin
                    w_posNext = COORD_W'(LIMIT);
                    w_dirNext = DIR_NEG;
                    flip      = 1'b1;
                end else begin
                    w_posNext = w_posUp[COORD_W-1:0];
                end
            end else begin
                if (w_posWide <= (COORD_W+1)'(STEP)) begin
                    w_posNext = '0;
                    w_dirNext = DIR_POS;
                    flip      = 1'b1;
                end else begin
                    w_posNext = r_pos - COORD_W'(STEP);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pos <= COORD_W'(INIT);
            r_dir <= DIR_POS;
        end else begin
            r_pos <= w_posNext;
            r_dir <= w_dirNext;
        end
    end

    assign pos = r_pos;

endmodule

// File: rtl/vga_bouncing_box.sv
// Pixel generator drawing a square that bounces once per frame on a background colour.
// Optional macro BOUNCE_COLOR_EN xors the box colour with a count of bounces.
module vga_bouncing_box
    import vga_pkg::*;
#(
    parameter int                  COLOR_W  = 3,
    parameter int                  SIZE     = 40,
    parameter int                  STEP     = 1,
    parameter int                  X_INIT   = 320,
    parameter int                  Y_INIT   = 220,
    parameter logic [COLOR_W-1:0]  BG_COLOR = 3'b110
) (
    input  logic                   clk,
    input  logic                   reset,
    vga_bouncing_box_if.slave      bus
);

    logic               r_tickMatchD;
    logic [COLOR_W-1:0] r_rgb;
    logic               w_match;
    logic               w_frameTick;
    logic               w_stepEn;
    logic [COORD_W-1:0] w_xPos;
    logic [COORD_W-1:0] w_yPos;
    logic               w_flipX;
    logic               w_flipY;
    logic               w_squareOn;
    logic [COLOR_W-1:0] w_boxColor;
    logic [COORD_W:0]   w_xEnd;
    logic [COORD_W:0]   w_yEnd;

    // The first blanking line start is held for several clocks on slow pixel clocks; fire once.
    assign w_match     = (bus.pixel_y == COORD_W'(V_VISIBLE)) && (bus.pixel_x == '0);
    assign w_frameTick = w_match && !r_tickMatchD;
    assign w_stepEn    = w_frameTick && !bus.pause;

    box_axis #(.LIMIT(H_VISIBLE - SIZE), .STEP(STEP), .INIT(X_INIT)) u_axisX (
        .clk     (clk),
        .reset   (reset),
        .step_en (w_stepEn),
        .pos     (w_xPos),
        .flip    (w_flipX)
    );

    box_axis #(.LIMIT(V_VISIBLE - SIZE), .STEP(STEP), .INIT(Y_INIT)) u_axisY (
        .clk     (clk),
        .reset   (reset),
        .step_en (w_stepEn),
        .pos     (w_yPos),
        .flip    (w_flipY)
    );

    assign w_xEnd     = {1'b0, w_xPos} + (COORD_W+1)'(SIZE);
    assign w_yEnd     = {1'b0, w_yPos} + (COORD_W+1)'(SIZE);
    assign w_squareOn = (bus.pixel_x >= w_xPos) && ({1'b0, bus.pixel_x} < w_xEnd) &&
                        (bus.pixel_y >= w_yPos) && ({1'b0, bus.pixel_y} < w_yEnd);

`ifdef BOUNCE_COLOR_EN
    logic [COLOR_W-1:0] r_bounceCnt;

    // A corner hit flips both axes in one tick but counts as a single bounce.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bounceCnt <= '0;
        end else if (w_frameTick && (w_flipX || w_flipY)) begin
            r_bounceCnt <= r_bounceCnt + 1'b1;
        end
    end

    assign w_boxColor = bus.switch ^ r_bounceCnt;
`else
    logic w_unusedFlips;

    assign w_unusedFlips = w_flipX | w_flipY;
    assign w_boxColor    = bus.switch;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tickMatchD <= 1'b0;
            r_rgb        <= '0;
        end else begin
            r_tickMatchD <= w_match;
            if (!bus.video_on) begin
                r_rgb <= '0;
            end else if (w_squareOn) begin
                r_rgb <= w_boxColor;
            end else begin
                r_rgb <= BG_COLOR;
            end
        end
    end

    assign bus.rgb = r_rgb;

endmodule

// File: tb/tb_vga_bouncing_box.sv
// Scoreboard bench for vga_bouncing_box: stimulus pushes expected rgb, a monitor pops
// one entry per clock and compares; box position is inferred by probing edge pixels.
module tb_vga_bouncing_box;
    import vga_pkg::*;

    typedef struct {
        logic       check;
        logic [2:0] exp;
        string      name;
    } exp_t;

    localparam logic [2:0] SQ = 3'b011;
    localparam logic [2:0] BG = 3'b110;

    logic clk = 1'b0;
    logic reset;
    exp_t sbQueue[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    vga_bouncing_box_if #(.COLOR_W(3)) bus ();

    vga_bouncing_box #(
        .COLOR_W  (3),
        .SIZE     (40),
        .STEP     (1),
        .X_INIT   (320),
        .Y_INIT   (220),
        .BG_COLOR (3'b110)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Monitor: each expectation was pushed at a negedge and is due after the next posedge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbQueue.size() > 0) begin
                e = sbQueue.pop_front();
                if (e.check) begin
                    checks++;
                    if (bus.rgb !== e.exp) begin
                        errors++;
                        $display("[TB] FAIL %s: rgb=%b expected %b", e.name, bus.rgb, e.exp);
                    end
                end
            end
        end
    end

    task automatic driveInputs(input int x, input int y, input logic vo);
        bus.pixel_x  = 10'(x);
        bus.pixel_y  = 10'(y);
        bus.video_on = vo;
    endtask

    task automatic applyStimulus(input int x, input int y, input logic vo);
        exp_t e;
        @(negedge clk);
        driveInputs(x, y, vo);
        e.check = 1'b0;
        e.exp   = 3'b000;
        e.name  = "idle";
        sbQueue.push_back(e);
    endtask

    task automatic checkOutput(input int x, input int y, input logic vo,
                               input logic [2:0] exp, input string name);
        exp_t e;
        @(negedge clk);
        driveInputs(x, y, vo);
        e.check = 1'b1;
        e.exp   = exp;
        e.name  = name;
        sbQueue.push_back(e);
    endtask

    task automatic frameTicks(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(0, 480, 1'b0);
            applyStimulus(1, 480, 1'b0);
        end
    endtask

    // Square corners inside, pixels just outside on the left/top/right/bottom.
    task automatic probeBox(input int x, input int y, input string tag);
        checkOutput(x,      y,      1'b1, SQ, {tag, "_topLeft"});
        checkOutput(x + 39, y + 39, 1'b1, SQ, {tag, "_botRight"});
        checkOutput(x - 1,  y,      1'b1, BG, {tag, "_leftOut"});
        checkOutput(x,      y - 1,  1'b1, BG, {tag, "_topOut"});
        checkOutput(x + 40, y,      1'b1, BG, {tag, "_rightOut"});
        checkOutput(x,      y + 40, 1'b1, BG, {tag, "_botOut"});
    endtask

    initial begin
        reset      = 1'b1;
        bus.switch = SQ;
        bus.pause  = 1'b0;
        driveInputs(0, 0, 1'b0);

        checkOutput(330, 230, 1'b1, 3'b000, "rgbDuringReset");
        @(negedge clk);
        reset = 1'b0;

        checkOutput(330, 230, 1'b1, SQ,     "drawSquare");
        checkOutput(100, 100, 1'b1, BG,     "drawBackground");
        checkOutput(330, 230, 1'b0, 3'b000, "drawBlanked");

        // Holding (0,480) for four clocks must move the box by only one step.
        for (int i = 0; i < 4; i++) applyStimulus(0, 480, 1'b0);
        applyStimulus(1, 480, 1'b0);
        checkOutput(320, 220, 1'b1, BG, "oneTickOldCorner");
        checkOutput(360, 260, 1'b1, SQ, "oneTickNewFarCorner");
        probeBox(321, 221, "tick1");

        frameTicks(219);
        probeBox(540, 440, "tick220");
        frameTicks(1);
        probeBox(541, 439, "tick221");
        frameTicks(59);
        probeBox(600, 380, "tick280");
        frameTicks(1);
        probeBox(599, 379, "tick281");

        bus.pause = 1'b1;
        frameTicks(5);
        probeBox(599, 379, "paused");
        bus.pause = 1'b0;
        frameTicks(1);
        probeBox(598, 378, "afterPause");

        frameTicks(50);
        checkOutput(548, 328, 1'b1, SQ, "preResetSquare");
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        checks++;
        if (bus.rgb !== 3'b000) begin
            errors++;
            $display("[TB] FAIL asyncResetRgb: rgb=%b expected %b", bus.rgb, 3'b000);
        end
        checkOutput(548, 328, 1'b1, 3'b000, "rgbHeldInReset");
        checkOutput(330, 230, 1'b1, 3'b000, "rgbHeldInReset2");
        @(negedge clk);
        reset = 1'b0;
        probeBox(320, 220, "afterReset");
        frameTicks(1);
        probeBox(321, 221, "firstTickAfterReset");

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sbQueue.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboardDrain: pending=%0d expected 0", sbQueue.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
